led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
- Scheduler for the board's 8-LED bank. Replaces the fixed free-running 4 s timer with a commanded sequencer.
- Accepts mode/period commands over a valid/ready handshake. Applies them on step boundaries and drives the LED bus through chase, bounce or blink patterns.
- Sits between the board-level control logic (buttons/UART decoder) and the LED pins.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz. Must be a multiple of 1000.
- STEP_MS, 500, default step period in ms, used when cmd_period = 0.
- LED_W, 8, LED bus width, min 2.

Ports:
- clk  in  1  system clock, 50 MHz on board.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_mode  in  2  command mode: 0 STOP, 1 CHASE, 2 BOUNCE, 3 BLINK.
- cmd_period  in  16  step period in ms. 0 selects STEP_MS.
- led  out  LED_W  LED drive, 1 = lit.
- step_tick  out  1  one-cycle pulse on every pattern step.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, led=0, cmd_ready=1, step_tick=0, busy=0, all counters 0, direction=up, mode=STOP. Reset mid-run aborts immediately; the pending command is discarded.
- Handshake: a command is accepted when cmd_valid & cmd_ready on a rising clk edge. cmd_mode and cmd_period are captured on that edge. cmd_valid held while ready=0 is not accepted.
- ms prescaler: counts 0..CLK_HZ/1000-1 and emits an internal ms_tick at the terminal count. It runs only in RUN/PENDING and is cleared on every step and on command application.
- Step counter: counts ms_ticks 0..period-1. At the terminal ms_tick it asserts step_tick for 1 cycle and advances the pattern in the same edge.
- Effective period: cmd_period, or STEP_MS if cmd_period=0. 16-bit, no saturation needed.
- FSM states: IDLE, RUN, PENDING.
- IDLE:
  - cmd_ready=1.
  - Accepted non-STOP command → RUN next cycle. led loaded on the accept edge: CHASE/BOUNCE = 1 (bit0), BLINK = all ones. Direction = up, counters cleared.
  - Accepted STOP → stays IDLE, led=0.
- RUN:
  - cmd_ready=1.
  - Accepted command → PENDING. The command is held and the current pattern continues.
- PENDING:
  - cmd_ready=0.
  - At the next step boundary the held command is applied instead of advancing. Non-STOP reloads the initial pattern and period, then → RUN. STOP sets led=0, then → IDLE.
  - step_tick still pulses on that boundary.
- Pattern advance per step:
  - CHASE: rotate left; MSB wraps to bit0.
  - BOUNCE: shift toward MSB while up. On reaching MSB, direction=down; shift toward bit0; on bit0, direction=up. Ends never light twice in a row (sequence for W=8: 01,02,…,80,40,…,01,02…).
  - BLINK: invert led (all ones ↔ all zeros).
- Simultaneous events: a command accepted on the same edge as a step boundary in RUN does not affect that step. It is applied on the following boundary.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro LED_SEQ_PAUSE_EN.
- When defined: adds input port pause (1 bit). While pause=1 in RUN/PENDING, the prescaler and step counter freeze, led holds, step_tick=0, and the handshake continues normally. Releasing pause resumes counting from the frozen values.
- When undefined: no pause port; counters always run.

Test Plan (CLK_HZ=8000 → 8 clk/ms, STEP_MS=2 → 16 clk/step, LED_W=8):
- Reset then idle 100 clk → led=0x00, cmd_ready=1, busy=0, no step_tick.
- CHASE, period 0 → led=0x01 after accept. step_tick every 16 clk; led 0x02,0x04,…,0x80, then 0x01 on the 8th step.
- BOUNCE, period 1 → step every 8 clk. led sequence 01,02,04,…,80,40,20,…,01,02; 0x80 and 0x01 each appear once per turn.
- In CHASE at led=0x04, issue BLINK period 3 → cmd_ready=0 until next boundary. At boundary led=0xFF, then toggles 0x00/0xFF every 24 clk.
- RUN, issue STOP → led=0x00 and busy=0 at next boundary. Assert rst mid-step → led=0x00 asynchronously; pending command lost.
- (LED_SEQ_PAUSE_EN) CHASE, pause=1 for 50 clk mid-step → led held, no step_tick. Remaining step clocks complete after release.

Source files
------------

// File: rtl/led_seq_if.sv
// Command handshake and LED output bundle for led_seq_ctrl.
// The master side issues commands; the slave side drives the LED bank.
interface led_seq_if #(
  parameter int LED_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [15:0]      cmd_period;
  logic [LED_W-1:0] led;
  logic             step_tick;
  logic             busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_period,
    input  cmd_ready, led, step_tick, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_period,
    output cmd_ready, led, step_tick, busy
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// Commanded chase/bounce/blink sequencer for the LED bank; commands apply on step boundaries.
// Defining LED_SEQ_PAUSE_EN adds a pause input that freezes the step timing.
module led_seq_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_MS = 500,
  parameter int LED_W   = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef LED_SEQ_PAUSE_EN
  input  logic pause,
`endif
  led_seq_if.slave bus
);
  localparam int PRESC_N = CLK_HZ / 1000;
  localparam int PRESC_W = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_N - 1);

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_e;
  typedef enum logic [1:0] {M_STOP, M_CHASE, M_BOUNCE, M_BLINK} mode_e;

  state_e             state, state_nx;
  mode_e              mode, mode_nx, pend_mode, pend_mode_nx, cmd_mode_e;
  logic [15:0]        period, period_nx, pend_period, pend_period_nx, cmd_eff;
  logic [15:0]        step_cnt, step_nx;
  logic [PRESC_W-1:0] presc, presc_nx;
  logic [LED_W-1:0]   led_q, led_nx;
  logic               dir_up, dir_nx, tick_q, tick_nx, busy_q;
  logic               run_en, ms_tick, step_edge, accept, ready_c;

  function automatic logic [LED_W-1:0] pat_init(input mode_e m);
    return (m == M_BLINK) ? {LED_W{1'b1}} : LED_W'(1);
  endfunction

`ifdef LED_SEQ_PAUSE_EN
  assign run_en = (state != IDLE) && !pause;
`else
  assign run_en = (state != IDLE);
`endif

  assign ready_c    = (state != PENDING);
  assign accept     = bus.cmd_valid && ready_c;
  assign cmd_mode_e = mode_e'(bus.cmd_mode);
  assign cmd_eff    = (bus.cmd_period == 16'd0) ? 16'(STEP_MS) : bus.cmd_period;
  assign ms_tick    = run_en && (presc == PRESC_LAST);
  assign step_edge  = ms_tick && (step_cnt == period - 16'd1);

  always_comb begin
    state_nx       = state;
    mode_nx        = mode;
    period_nx      = period;
    pend_mode_nx   = pend_mode;
    pend_period_nx = pend_period;
    step_nx        = step_cnt;
    presc_nx       = presc;
    led_nx         = led_q;
    dir_nx         = dir_up;
    tick_nx        = 1'b0;

    if (run_en) begin
      if (step_edge) begin
        presc_nx = '0;
        step_nx  = '0;
        tick_nx  = 1'b1;
      end else if (ms_tick) begin
        presc_nx = '0;
        step_nx  = step_cnt + 16'd1;
      end else begin
        presc_nx = presc + PRESC_W'(1);
      end
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_mode_e == M_STOP) begin
            led_nx = '0;
          end else begin
            state_nx  = RUN;
            mode_nx   = cmd_mode_e;
            period_nx = cmd_eff;
            led_nx    = pat_init(cmd_mode_e);
            dir_nx    = 1'b1;
            presc_nx  = '0;
            step_nx   = '0;
          end
        end
      end
      RUN: begin
        if (step_edge) begin
          unique case (mode)
            M_CHASE: led_nx = {led_q[LED_W-2:0], led_q[LED_W-1]};
            M_BOUNCE: begin
              // direction flips on the step that lands on an end, so ends never repeat
              if (dir_up) begin
                led_nx = led_q << 1;
                dir_nx = !led_nx[LED_W-1];
              end else begin
                led_nx = led_q >> 1;
                dir_nx = led_nx[0];
              end
            end
            M_BLINK: led_nx = ~led_q;
            default: led_nx = led_q;
          endcase
        end
        if (accept) begin
          pend_mode_nx   = cmd_mode_e;
          pend_period_nx = cmd_eff;
          state_nx       = PENDING;
        end
      end
      PENDING: begin
        if (step_edge) begin
          if (pend_mode == M_STOP) begin
            led_nx   = '0;
            mode_nx  = M_STOP;
            state_nx = IDLE;
          end else begin
            mode_nx   = pend_mode;
            period_nx = pend_period;
            led_nx    = pat_init(pend_mode);
            dir_nx    = 1'b1;
            state_nx  = RUN;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode        <= M_STOP;
      period      <= '0;
      pend_mode   <= M_STOP;
      pend_period <= '0;
      step_cnt    <= '0;
      presc       <= '0;
      led_q       <= '0;
      dir_up      <= 1'b1;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      mode        <= mode_nx;
      period      <= period_nx;
      pend_mode   <= pend_mode_nx;
      pend_period <= pend_period_nx;
      step_cnt    <= step_nx;
      presc       <= presc_nx;
      led_q       <= led_nx;
      dir_up      <= dir_nx;
      tick_q      <= tick_nx;
      busy_q      <= (state_nx != IDLE);
    end
  end

  assign bus.cmd_ready = ready_c;
  assign bus.led       = led_q;
  assign bus.step_tick = tick_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: a step-index reference model predicts LED patterns,
// handshake and tick timing; a negedge monitor compares against the DUT.
module tb_led_seq_ctrl;
  localparam int CLK_HZ  = 8000;
  localparam int STEP_MS = 2;
  localparam int LED_W   = 8;
  localparam int CPM     = CLK_HZ / 1000;

  logic clk = 1'b0;
  logic rst;
  logic pause;
  int   total = 0;
  int   bad   = 0;

  led_seq_if #(.LED_W(LED_W)) bus ();

  led_seq_ctrl #(.CLK_HZ(CLK_HZ), .STEP_MS(STEP_MS), .LED_W(LED_W)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef LED_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern as a function of the step index since the pattern was loaded.
  function automatic int pat(input int md, input int k);
    int p;
    case (md)
      1: return 1 << (k % LED_W);
      2: begin
        p = k % (2 * LED_W - 2);
        return 1 << ((p < LED_W) ? p : (2 * LED_W - 2 - p));
      end
      3: return ((k % 2) == 0) ? 'hFF : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int clk_per(input int pr);
    return ((pr == 0) ? STEP_MS : pr) * CPM;
  endfunction

  // reference model state
  bit m_active, m_pend, m_tick, m_acc, m_bnd;
  int m_mode, m_pclk, m_k, m_cnt, m_led, m_pmode, m_pper;
  int exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_pend = 0; m_tick = 0; m_cnt = 0; m_k = 0;
      m_led = 0; m_mode = 0; m_pclk = 1;
      exp_q.delete();
    end else begin
      m_acc  = bus.cmd_valid && !m_pend;
      m_bnd  = m_active && !pause && (m_cnt == m_pclk - 1);
      m_tick = m_bnd;
      if (m_bnd) begin
        m_cnt = 0;
        if (m_pend) begin
          m_pend = 0;
          if (m_pmode == 0) begin
            m_active = 0;
            m_led    = 0;
          end else begin
            m_mode = m_pmode;
            m_pclk = clk_per(m_pper);
            m_k    = 0;
            m_led  = pat(m_mode, 0);
          end
        end else begin
          m_k++;
          m_led = pat(m_mode, m_k);
        end
        exp_q.push_back(m_led);
      end else if (m_active && !pause) begin
        m_cnt++;
      end
      if (m_acc) begin
        if (m_active) begin
          m_pend  = 1;
          m_pmode = int'(bus.cmd_mode);
          m_pper  = int'(bus.cmd_period);
        end else if (bus.cmd_mode == 2'd0) begin
          m_led = 0;
        end else begin
          m_active = 1;
          m_mode   = int'(bus.cmd_mode);
          m_pclk   = clk_per(int'(bus.cmd_period));
          m_k      = 0;
          m_cnt    = 0;
          m_led    = pat(m_mode, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("led", int'(bus.led), m_led);
    check("cmd_ready", int'(bus.cmd_ready), int'(!m_pend));
    check("busy", int'(bus.busy), int'(m_active));
    check("step_tick", int'(bus.step_tick), int'(m_tick));
    if (bus.step_tick) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got tick with led 0x%0h, expected no tick", bus.led);
      end else begin
        check("sb_step_led", int'(bus.led), exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [1:0] md, input logic [15:0] pr);
    int n;
    bit acc;
    bus.cmd_valid  = 1'b1;
    bus.cmd_mode   = md;
    bus.cmd_period = pr;
    n   = 0;
    acc = 0;
    while (!acc && n < 300) begin
      acc = bus.cmd_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept in %0d clk, expected accept", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int i;
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 2'd0;
    bus.cmd_period = 16'd0;
    pause = 1'b0;
    rst   = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(100);

    send(2'd1, 16'd0);
    idle(150);
    send(2'd0, 16'd0);
    idle(30);

    send(2'd2, 16'd1);
    idle(140);
    send(2'd0, 16'd0);
    idle(20);

    send(2'd1, 16'd0);
    i = 0;
    while (bus.led != 8'h04 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("reach_led_04", int'(bus.led), 'h04);
    send(2'd3, 16'd3);
    idle(100);
    send(2'd0, 16'd0);
    idle(40);

    send(2'd1, 16'd0);
    idle(5);
    send(2'd3, 16'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_led", int'(bus.led), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_ready", int'(bus.cmd_ready), 1);
    idle(2);
    rst = 1'b0;
    idle(50);

`ifdef LED_SEQ_PAUSE_EN
    send(2'd1, 16'd0);
    idle(20);
    pause = 1'b1;
    idle(50);
    pause = 1'b0;
    idle(40);
    send(2'd0, 16'd0);
    idle(20);
`endif

    for (int r = 0; r < 40; r++) begin
      send(2'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
      idle($urandom_range(0, 80));
    end
    send(2'd0, 16'd0);
    idle(60);

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
